// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR sample path: word type and
// active-low 7-segment patterns {g,f,e,d,c,b,a}.
package lfsr_pkg;

  localparam int LFSR_W = 8;

  typedef logic [LFSR_W-1:0] lfsr_word_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_dec
  import lfsr_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/lfsr_sample_fifo.sv
// Samples the LFSR word every PERIOD cycles of shift mode into a small FIFO
// with valid/ready output and sticky overflow. Define LFSR_SAMPLE_SEG_EN for
// registered hex_lo/hex_hi 7-segment views of the FIFO head.
module lfsr_sample_fifo
  import lfsr_pkg::*;
#(
  parameter int WIDTH  = LFSR_W,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rand_in,
  input  logic                     run,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef LFSR_SAMPLE_SEG_EN
  ,
  output logic [6:0]               hex_lo,
  output logic [6:0]               hex_hi
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lfsr_sample_fifo: DEPTH must be a power of two >= 2");
  end
  if (PERIOD < 1) begin : g_bad_period
    $error("lfsr_sample_fifo: PERIOD must be >= 1");
  end

  logic [CW-1:0]    samp_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;

  assign push      = run && (samp_cnt == CW'(PERIOD - 1));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == (AW + 1)'(DEPTH));
  assign accept    = push && (!full || pop);
  // Empty FIFO shows zero rather than stale storage.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      samp_cnt <= '0;
    else if (!run || push)
      samp_cnt <= '0;
    else
      samp_cnt <= samp_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= rand_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear wins so no loss goes unreported.
      if (push && !accept)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

`ifdef LFSR_SAMPLE_SEG_EN
  if (WIDTH != 8) begin : g_bad_seg_width
    $error("lfsr_sample_fifo: LFSR_SAMPLE_SEG_EN requires WIDTH == 8");
  end

  logic [6:0] seg_lo;
  logic [6:0] seg_hi;

  seg7_hex_dec u_dec_lo (.hex(out_data[3:0]), .seg(seg_lo));
  seg7_hex_dec u_dec_hi (.hex(out_data[7:4]), .seg(seg_hi));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_lo <= SEG_OFF;
      hex_hi <= SEG_OFF;
    end else if (out_valid) begin
      hex_lo <= seg_lo;
      hex_hi <= seg_hi;
    end else begin
      hex_lo <= SEG_OFF;
      hex_hi <= SEG_OFF;
    end
  end
`endif

endmodule
